mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Single-port memory controller and arbiter between the instruction-cache miss path and the load/store buffer.
- Drives the byte-wide external RAM/IO bus.
- Serialises multi-byte reads and writes into byte transactions.
- Arbitrates round-robin on contention; aborts speculative traffic on a branch misprediction flush from the ROB.

Parameters:
ADDR_W, 32, address width of mem_a, ic_addr and ls_addr
IO_HI, 2'b11, value of addr[17:16] that selects the IO region

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
rdy  in  1  chip ready; low freezes the block
mem_din  in  8  RAM read byte, valid one cycle after address issue
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write, 0 = read
io_buffer_full  in  1  IO write buffer full
ic_req  in  1  I-cache word fetch request, held until ic_done
ic_addr  in  32  fetch address, word aligned
ic_done  out  1  one-cycle pulse; ic_data valid
ic_data  out  32  fetched word, little-endian
ls_req  in  1  LSB request, held until ls_done
ls_wr  in  1  1 = store
ls_addr  in  32  byte address
ls_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes
ls_wdata  in  32  store data; low bytes used
ls_done  out  1  one-cycle pulse
ls_rdata  out  32  load data, zero-extended
flush  in  1  ROB jp_wrong; aborts fetches and loads

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- Reset (rst low at posedge):
  - Next state IDLE.
  - Outputs 0: mem_a, mem_dout, mem_wr, ic_done, ls_done, ic_data, ls_rdata.
  - Byte counter cnt = 0.
  - last_grant = LS, so the first contention goes to IC.
  - Reset mid-transaction abandons it; no done pulse.
- rdy low: all registers hold; mem_wr output forced 0; mem_a held. Capture stays correct because RAM keeps returning the held address.
- IDLE, arbitration at posedge:
  - Eligible requests: ic_req, and ls_req.
  - flush high: ic_req and load requests are not eligible.
  - One eligible request: grant it.
  - Both eligible: grant the one that is not last_grant; update last_grant.
  - Latch base address, n (IC: 4; LS: 1, 2 or 4 from ls_size; ls_size 3 is treated as 4), write data and owner.
  - Enter READ or WRITE with cnt = 0.
  - No grant: mem_a = 0, mem_wr = 0.
- READ, one cycle per byte plus drain:
  - Each cycle with cnt < n: drive mem_a = base + cnt, mem_wr = 0.
  - Each cycle with cnt >= 1: capture mem_din into byte cnt-1 of the data register.
  - cnt increments every cycle.
  - Leave to DONE at the edge where cnt == n, after the final capture.
  - n-byte read: done pulse in the cycle starting at E0+n+1, where E0 is the grant edge. Word fetch: E0+5.
- WRITE:
  - Each cycle: mem_a = base + cnt, mem_dout = byte cnt of wdata, mem_wr = 1, cnt++.
  - Go to DONE when cnt reaches n-1 at the edge, so done is at E0+n.
  - IO stall: if base[17:16] == IO_HI and io_buffer_full is high, drive mem_wr = 0 and hold cnt until it drops.
- DONE, one cycle:
  - Pulse the owner's done signal; drive data on ic_data or ls_rdata.
  - Requests are not sampled; next state IDLE.
  - Requesters drop req on seeing done.
- flush:
  - During READ owned by IC, or by a load: next state IDLE, cnt = 0, no done.
  - flush in the DONE cycle of an IC or load transaction: ic_done/ls_done gated to 0.
  - Stores are never aborted.
  - flush never affects last_grant.
- Address arithmetic: base + cnt is 32-bit, wraps modulo 2^32.
- ls_rdata and ic_data hold their last value until overwritten.

Test Plan:
1. Word fetch: ic_req with ic_addr = 0x100, RAM bytes 13 05 00 00 -> mem_a = 0x100..0x103 on consecutive cycles; ic_done at E0+5 with ic_data = 0x00000513; mem_wr = 0 throughout.
2. Store word: ls_wr = 1, ls_size = 2, ls_addr = 0x200, ls_wdata = 0xDEADBEEF -> mem_wr = 1 for 4 cycles; mem_dout EF, BE, AD, DE at 0x200..0x203; ls_done at E0+4.
3. Contention after reset: ic_req and ls_req (load) raised together -> IC granted first, LS granted the cycle after the IC DONE; on the next simultaneous pair, LS wins.
4. Flush: ic_req at 0x40, flush high in the 2nd READ cycle -> no ic_done; IDLE next cycle; a pending ls store is granted at the following edge.
5. IO store: 1 byte 0x41 to 0x30000, io_buffer_full high for 3 cycles after grant -> mem_wr = 0 for 3 cycles, then one write cycle; ls_done one cycle later.
6. Halfword load at 0x10 (bytes 34 12) with rdy low for 2 cycles mid-read -> ls_rdata = 0x00001234, latency +2 cycles. Separately, rst low mid-load -> IDLE and all outputs 0 next cycle, no ls_done.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bundle of the I-cache and load/store request channels plus the byte-wide RAM/IO bus.
// master is the controller side; slave is the requesters and external memory.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic [31:0]       ic_data;

    logic              ls_req;
    logic              ls_wr;
    logic [ADDR_W-1:0] ls_addr;
    logic [1:0]        ls_size;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;

    logic              flush;

    modport master (
        input  mem_din, io_buffer_full,
        input  ic_req, ic_addr,
        input  ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        input  flush,
        output mem_dout, mem_a, mem_wr,
        output ic_done, ic_data,
        output ls_done, ls_rdata
    );

    modport slave (
        output mem_din, io_buffer_full,
        output ic_req, ic_addr,
        output ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        output flush,
        input  mem_dout, mem_a, mem_wr,
        input  ic_done, ic_data,
        input  ls_done, ls_rdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port memory controller: round-robin arbiter between I-cache fetches and the
// load/store buffer, serialising word/halfword/byte accesses onto a byte-wide bus.
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef enum logic {OWN_IC, OWN_LS} owner_t;

    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic [ADDR_W-1:0] base;
    logic [2:0]        n;
    logic [2:0]        cnt;
    logic [31:0]       buf_q;
    logic              wr_q;

    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q;
    logic              ic_done_q;
    logic              ls_done_q;
    logic [31:0]       ic_data_q;
    logic [31:0]       ls_rdata_q;

    logic              ic_elig;
    logic              ls_elig;
    logic              grant_ic;
    logic              grant_ls;
    logic [ADDR_W-1:0] grant_addr;
    logic [2:0]        ls_n;
    logic [2:0]        cnt_inc;
    logic              io_stall;
    logic [31:0]       rd_word;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        ic_elig    = bus.ic_req && !bus.flush;
        ls_elig    = bus.ls_req && !(bus.flush && !bus.ls_wr);
        grant_ic   = ic_elig && (!ls_elig || last_grant == OWN_LS);
        grant_ls   = ls_elig && !grant_ic;
        grant_addr = grant_ic ? bus.ic_addr : bus.ls_addr;
        case (bus.ls_size)
            2'd0:    ls_n = 3'd1;
            2'd1:    ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase
        cnt_inc  = cnt + 3'd1;
        io_stall = (state == WRITE) && (base[17:16] == IO_HI) && bus.io_buffer_full;
        // The byte returned this cycle belongs to the address issued one cycle earlier.
        rd_word  = buf_q;
        for (int i = 0; i < 4; i++) begin
            if (cnt == 3'(i + 1)) rd_word[8*i +: 8] = bus.mem_din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_IC;
            last_grant <= OWN_LS;
            base       <= '0;
            n          <= '0;
            cnt        <= '0;
            buf_q      <= '0;
            wr_q       <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            ic_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            ic_data_q  <= '0;
            ls_rdata_q <= '0;
        end else if (rdy) begin
            ic_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    mem_a_q  <= '0;
                    mem_wr_q <= 1'b0;
                    if (grant_ic || grant_ls) begin
                        if (ic_elig && ls_elig) last_grant <= grant_ic ? OWN_IC : OWN_LS;
                        owner   <= grant_ic ? OWN_IC : OWN_LS;
                        base    <= grant_addr;
                        mem_a_q <= grant_addr;
                        n       <= grant_ic ? 3'd4 : ls_n;
                        wr_q    <= grant_ls && bus.ls_wr;
                        if (grant_ls && bus.ls_wr) begin
                            buf_q      <= bus.ls_wdata;
                            mem_dout_q <= bus.ls_wdata[7:0];
                            mem_wr_q   <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            buf_q <= '0;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (bus.flush) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        mem_a_q <= '0;
                    end else if (cnt == n) begin
                        buf_q   <= rd_word;
                        mem_a_q <= '0;
                        state   <= DONE;
                        if (owner == OWN_IC) begin
                            ic_done_q <= 1'b1;
                            ic_data_q <= rd_word;
                        end else begin
                            ls_done_q  <= 1'b1;
                            ls_rdata_q <= rd_word;
                        end
                    end else begin
                        buf_q   <= rd_word;
                        cnt     <= cnt_inc;
                        mem_a_q <= (cnt_inc < n) ? base + ADDR_W'(cnt_inc) : '0;
                    end
                end
                WRITE: begin
                    if (!io_stall) begin
                        if (cnt == n - 3'd1) begin
                            mem_wr_q  <= 1'b0;
                            mem_a_q   <= '0;
                            ls_done_q <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt        <= cnt_inc;
                            mem_a_q    <= base + ADDR_W'(cnt_inc);
                            mem_dout_q <= buf_q[{cnt_inc[1:0], 3'b000} +: 8];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Frozen cycles and IO back-pressure suppress the strobes; a flush kills the
    // done pulse of a fetch or load but never of a store.
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = mem_wr_q && rdy && !io_stall;
    assign bus.ic_done  = ic_done_q && rdy && !bus.flush;
    assign bus.ls_done  = ls_done_q && rdy && !(bus.flush && !wr_q);
    assign bus.ic_data  = ic_data_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed timing scenarios plus randomized fetch/load/store traffic,
// checked by a queue scoreboard fed from a byte-array memory model.
module tb_mem_ctrl;
    typedef struct {
        bit          is_store;
        logic [31:0] data;
    } ls_exp_t;

    logic clk;
    logic rst;
    logic rdy;
    logic rdy_dir;
    logic rdy_rnd = 1'b1;
    logic iof_dir;
    logic iof_rnd = 1'b0;
    bit   rnd_on;

    int total;
    int bad;
    int cyc;
    int c0;
    int t;

    logic [31:0] ic_q[$];
    ls_exp_t     ls_q[$];
    ls_exp_t     mon_e;

    logic [7:0] ram   [bit [31:0]];
    logic [7:0] model [bit [31:0]];

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.master)
    );

    assign rdy                = rdy_dir & rdy_rnd;
    assign bus.io_buffer_full = iof_dir | iof_rnd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        if (model.exists(a)) return model[a];
        return dflt(a);
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input int nb);
        logic [31:0] w = '0;
        for (int i = 0; i < nb; i++) w[8*i +: 8] = model_rd(a + 32'(i));
        return w;
    endfunction

    // RAM answers one cycle after the address and is stalled along with the chip.
    always @(posedge clk) begin
        if (rdy) begin
            if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
            bus.mem_din <= ram_rd(bus.mem_a);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_on) begin
            rdy_rnd = ($urandom_range(0, 5) != 0);
            iof_rnd = ($urandom_range(0, 3) == 0);
        end else begin
            rdy_rnd = 1'b1;
            iof_rnd = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.ic_done) begin
                if (ic_q.size() == 0) check("ic_spurious_done", 32'(bus.ic_done), 32'd0);
                else check("ic_data", bus.ic_data, ic_q.pop_front());
            end
            if (bus.ls_done) begin
                if (ls_q.size() == 0) begin
                    check("ls_spurious_done", 32'(bus.ls_done), 32'd0);
                end else begin
                    mon_e = ls_q.pop_front();
                    if (!mon_e.is_store) check("ls_rdata", bus.ls_rdata, mon_e.data);
                end
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a]   = d;
        model[a] = d;
    endtask

    task automatic issue_ic(input logic [31:0] a, input bit expect_done);
        if (expect_done) ic_q.push_back(model_load(a, 4));
        bus.ic_addr = a;
        bus.ic_req  = 1'b1;
    endtask

    task automatic issue_ls(input bit wr, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] wdata, input bit expect_done);
        ls_exp_t e;
        int nb = nbytes(size);
        e.is_store = wr;
        e.data     = '0;
        if (wr) begin
            for (int i = 0; i < nb; i++) model[a + 32'(i)] = wdata[8*i +: 8];
        end else begin
            e.data = model_load(a, nb);
        end
        if (expect_done) ls_q.push_back(e);
        bus.ls_wr    = wr;
        bus.ls_size  = size;
        bus.ls_addr  = a;
        bus.ls_wdata = wdata;
        bus.ls_req   = 1'b1;
    endtask

    task automatic wait_ic(output int at);
        bit seen = 1'b0;
        at = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.ic_done) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        check("ic_done_wait", 32'(seen), 32'd1);
    endtask

    task automatic wait_ls(output int at);
        bit seen = 1'b0;
        at = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.ls_done) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        check("ls_done_wait", 32'(seen), 32'd1);
    endtask

    task automatic ic_traffic();
        int tt;
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) adv();
            issue_ic(32'h1000 + 32'(4 * $urandom_range(0, 63)), 1'b1);
            wait_ic(tt);
            bus.ic_req = 1'b0;
        end
    endtask

    task automatic ls_traffic();
        int          tt;
        int          r;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] a;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) adv();
            r    = $urandom_range(0, 9);
            wr   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            if (wr) a = (r < 3) ? 32'h30000 + 32'($urandom_range(0, 15))
                                : 32'h8000 + 32'($urandom_range(0, 255));
            else    a = (r == 0) ? 32'hFFFF_FFFD : 32'h8000 + 32'($urandom_range(0, 255));
            issue_ls(wr, size, a, $urandom, 1'b1);
            wait_ls(tt);
            bus.ls_req = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] st_bytes [4];
        total = 0;
        bad   = 0;
        cyc   = 0;
        rnd_on = 1'b0;
        rst    = 1'b0;
        rdy_dir = 1'b1;
        iof_dir = 1'b0;
        bus.flush    = 1'b0;
        bus.ic_req   = 1'b0;
        bus.ic_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_wr    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_size  = '0;
        bus.ls_wdata = '0;
        bus.mem_din  = '0;
        preload(32'h100, 8'h13);
        preload(32'h101, 8'h05);
        preload(32'h102, 8'h00);
        preload(32'h103, 8'h00);
        preload(32'h10, 8'h34);
        preload(32'h11, 8'h12);

        repeat (3) adv();
        rst = 1'b1;
        smp();
        check("rst_mem_a", bus.mem_a, 32'h0);
        check("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
        check("rst_ic_done", 32'(bus.ic_done), 32'h0);
        check("rst_ls_done", 32'(bus.ls_done), 32'h0);
        check("rst_ic_data", bus.ic_data, 32'h0);
        check("rst_ls_rdata", bus.ls_rdata, 32'h0);

        // Word fetch: four byte addresses, done five cycles after grant.
        adv();
        issue_ic(32'h100, 1'b1);
        adv();
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            smp();
            check("fetch_mem_a", bus.mem_a, 32'h100 + 32'(k));
            check("fetch_mem_wr", 32'(bus.mem_wr), 32'h0);
            if (k < 3) adv();
        end
        wait_ic(t);
        bus.ic_req = 1'b0;
        check("fetch_latency", 32'(t - c0), 32'd5);

        // Store word: little-endian bytes on consecutive cycles, done at grant+4.
        adv();
        adv();
        st_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        issue_ls(1'b1, 2'd2, 32'h200, 32'hDEADBEEF, 1'b1);
        adv();
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            smp();
            check("store_mem_wr", 32'(bus.mem_wr), 32'h1);
            check("store_mem_a", bus.mem_a, 32'h200 + 32'(k));
            check("store_mem_dout", 32'(bus.mem_dout), 32'(st_bytes[k]));
            adv();
        end
        wait_ls(t);
        bus.ls_req = 1'b0;
        check("store_latency", 32'(t - c0), 32'd4);

        // Contention: first pair goes to IC, the next pair to LS.
        adv();
        adv();
        issue_ic(32'h100, 1'b1);
        issue_ls(1'b0, 2'd2, 32'h200, 32'h0, 1'b1);
        adv();
        smp();
        check("arb1_first_ic", bus.mem_a, 32'h100);
        wait_ic(t);
        bus.ic_req = 1'b0;
        adv();
        adv();
        smp();
        check("arb1_then_ls", bus.mem_a, 32'h200);
        wait_ls(t);
        bus.ls_req = 1'b0;
        adv();
        adv();
        issue_ic(32'h104, 1'b1);
        issue_ls(1'b0, 2'd0, 32'h202, 32'h0, 1'b1);
        adv();
        smp();
        check("arb2_first_ls", bus.mem_a, 32'h202);
        wait_ls(t);
        bus.ls_req = 1'b0;
        wait_ic(t);
        bus.ic_req = 1'b0;

        // Flush in the second read cycle aborts the fetch; the pending store follows.
        adv();
        adv();
        issue_ic(32'h40, 1'b0);
        issue_ls(1'b1, 2'd0, 32'h300, 32'h0000_0077, 1'b1);
        adv();
        smp();
        check("flush_fetch_a", bus.mem_a, 32'h40);
        adv();
        bus.flush = 1'b1;
        adv();
        bus.flush  = 1'b0;
        bus.ic_req = 1'b0;
        smp();
        check("flush_idle_a", bus.mem_a, 32'h0);
        check("flush_idle_wr", 32'(bus.mem_wr), 32'h0);
        adv();
        smp();
        check("flush_store_wr", 32'(bus.mem_wr), 32'h1);
        check("flush_store_a", bus.mem_a, 32'h300);
        check("flush_store_dout", 32'(bus.mem_dout), 32'h77);
        wait_ls(t);
        bus.ls_req = 1'b0;

        // IO store held off by a full IO buffer for three cycles.
        adv();
        adv();
        issue_ls(1'b1, 2'd0, 32'h30000, 32'h0000_0041, 1'b1);
        iof_dir = 1'b1;
        adv();
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            smp();
            check("io_stall_wr", 32'(bus.mem_wr), 32'h0);
            adv();
        end
        iof_dir = 1'b0;
        smp();
        check("io_write_wr", 32'(bus.mem_wr), 32'h1);
        check("io_write_a", bus.mem_a, 32'h30000);
        check("io_write_dout", 32'(bus.mem_dout), 32'h41);
        wait_ls(t);
        bus.ls_req = 1'b0;
        check("io_latency", 32'(t - c0), 32'd4);

        // Flush in the DONE cycle of a fetch suppresses ic_done.
        adv();
        adv();
        issue_ic(32'h1100, 1'b0);
        repeat (6) adv();
        bus.flush = 1'b1;
        smp();
        check("flush_done_gate", 32'(bus.ic_done), 32'h0);
        adv();
        bus.flush  = 1'b0;
        bus.ic_req = 1'b0;

        // Halfword load with two frozen cycles mid-read.
        adv();
        issue_ls(1'b0, 2'd1, 32'h10, 32'h0, 1'b1);
        adv();
        c0 = cyc;
        adv();
        rdy_dir = 1'b0;
        adv();
        smp();
        check("freeze_mem_a", bus.mem_a, 32'h11);
        check("freeze_mem_wr", 32'(bus.mem_wr), 32'h0);
        adv();
        rdy_dir = 1'b1;
        wait_ls(t);
        bus.ls_req = 1'b0;
        check("freeze_latency", 32'(t - c0), 32'd5);

        // Reset in the middle of a load abandons it.
        adv();
        adv();
        issue_ls(1'b0, 2'd1, 32'h10, 32'h0, 1'b0);
        adv();
        adv();
        rst = 1'b0;
        adv();
        smp();
        check("midrst_mem_a", bus.mem_a, 32'h0);
        check("midrst_ls_done", 32'(bus.ls_done), 32'h0);
        check("midrst_ls_rdata", bus.ls_rdata, 32'h0);
        check("midrst_ic_data", bus.ic_data, 32'h0);
        rst        = 1'b1;
        bus.ls_req = 1'b0;
        repeat (4) adv();

        // Randomized concurrent traffic with random stalls and IO back-pressure.
        rnd_on = 1'b1;
        fork
            ic_traffic();
            ls_traffic();
        join
        rnd_on = 1'b0;
        repeat (6) adv();
        check("ic_queue_left", 32'(ic_q.size()), 32'd0);
        check("ls_queue_left", 32'(ls_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
